// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch stage in front of the ALU.
// Holds a 32 x 32 register file with combinational reads and one write port.
// One instruction is held in a valid/ready output register slice.
// An issue counter records how many instructions were accepted.
// Optional build macro: OPERAND_BYPASS_EN. When it is defined, a same-cycle
// writeback to a source register is forwarded into that operand
// (write-through). When it is undefined, a same-cycle read returns the old value.
module alu_operand_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [31:0]      imm,
    input  logic             use_imm,
    input  logic [3:0]       alu_ctrl_in,
    input  logic [4:0]       rd_addr_in,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALUControl,
    output logic [31:0]      A,
    output logic [31:0]      B,
    output logic [4:0]       rd_addr_out,
    output logic [CNT_W-1:0] issue_count
);

`ifdef OPERAND_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // Entry 0 is hardwired to zero, so only entries 1..31 are stored.
    logic [31:0]      rf_q [1:31];
    logic [31:0]      rf_d [1:31];
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0] issue_count_q, issue_count_d;

    // The write port updates the addressed entry. Address 0 has no storage, so writes to it are dropped.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            rf_d[i] = rf_q[i];
            if (wb_en && (wb_addr == 5'(i))) begin
                rf_d[i] = wb_data;
            end
        end
    end

    // Register file storage. Reset clears every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // Combinational source reads. Address 0 reads as zero. An optional same-cycle writeback is forwarded.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr == 5'(i)) rs1_val = rf_q[i];
            if (rs2_addr == 5'(i)) rs2_val = rf_q[i];
        end
        if (BYPASS_EN && wb_en && (wb_addr != 5'd0) && (wb_addr == rs1_addr)) rs1_val = wb_data;
        if (BYPASS_EN && wb_en && (wb_addr != 5'd0) && (wb_addr == rs2_addr)) rs2_val = wb_data;
    end

    // Handshake and next-state computation for the output slice and the issue counter.
    always_comb begin
        in_ready      = (!out_valid_q || out_ready) && !flush;
        accept        = in_valid && in_ready;
        a_d           = a_q;
        b_d           = b_q;
        alu_ctrl_d    = alu_ctrl_q;
        rd_addr_d     = rd_addr_q;
        issue_count_d = issue_count_q;
        out_valid_d   = out_valid_q && !out_ready;
        if (accept) begin
            a_d           = rs1_val;
            b_d           = use_imm ? imm : rs2_val;
            alu_ctrl_d    = alu_ctrl_in;
            rd_addr_d     = rd_addr_in;
            issue_count_d = issue_count_q + CNT_W'(1);
            out_valid_d   = 1'b1;
        end
        if (flush) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slice and issue counter registers. Reset discards any held instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            alu_ctrl_q    <= '0;
            rd_addr_q     <= '0;
            issue_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            a_q           <= a_d;
            b_q           <= b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rd_addr_q     <= rd_addr_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign ALUControl  = alu_ctrl_q;
    assign rd_addr_out = rd_addr_q;
    assign issue_count = issue_count_q;

endmodule
